instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
PC-generation and fetch stage sitting directly upstream of instruction_memory. It drives the memory address and read enable, and absorbs the memory's one-cycle registered read latency. It presents a valid instruction/PC pair to decode, with stall holding and branch/jump redirect flushing. Memory words are 32-bit and addressed by byte address.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, value driven on if_instr whenever if_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_addr  out  32  byte address to instruction_memory addr.
imem_read_en  out  1  read enable to instruction_memory read_en.
imem_data_in  in  32  instruction_memory data_out; holds the word for the address presented in the previous cycle with read_en=1.
stall  in  1  decode not accepting; hold current output.
redirect_valid  in  1  branch/jump taken; flush and refetch.
redirect_pc  in  32  redirect target byte address.
if_valid  out  1  if_instr/if_pc hold a live instruction.
if_pc  out  32  PC of if_instr.
if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
if_instr  out  32  fetched instruction; NOP_INSTR when if_valid=0.
fetch_misaligned  out  1  one-cycle pulse, cycle after a redirect with redirect_pc[1:0]!=0.

Behaviour:
- Registers:
  - pc: next address to issue.
  - inflight_pc: address issued last cycle.
  - hold_instr, hold_pc: skid capture.
  - state: IDLE, RUN or HOLD.
  - fetch_misaligned.
- Reset (async):
  - pc=RESET_PC, inflight_pc=hold_pc=RESET_PC, hold_instr=NOP_INSTR, state=IDLE, fetch_misaligned=0.
  - While reset is high: imem_read_en=0, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC.
- imem_addr = pc in all states.
- Acceptance: decode takes an instruction at a rising edge where if_valid=1 and stall=0.
- IDLE (no response pending):
  - imem_read_en=1, if_valid=0.
  - Next edge: inflight_pc<=pc, pc<=pc+4, go to RUN.
  - stall is ignored in IDLE.
- RUN (imem_data_in is the word for inflight_pc):
  - if_valid=1, if_instr=imem_data_in, if_pc=inflight_pc.
  - redirect_valid=1: if_valid forced 0 this cycle, imem_read_en=0, pc<=redirect_pc with bits[1:0] forced to 0, go to IDLE.
  - else stall=1: imem_read_en=0, hold_instr<=imem_data_in, hold_pc<=inflight_pc, pc unchanged, go to HOLD.
  - else: imem_read_en=1, inflight_pc<=pc, pc<=pc+4, stay in RUN.
- HOLD:
  - if_valid=1, if_instr=hold_instr, if_pc=hold_pc.
  - redirect_valid=1: same action as in RUN, go to IDLE.
  - else stall=1: imem_read_en=0, stay in HOLD.
  - else (held word accepted this edge): imem_read_en=1, inflight_pc<=pc, pc<=pc+4, go to RUN. No bubble, no duplicate.
- Priority: reset > redirect_valid > stall.
- fetch_misaligned <= redirect_valid & (redirect_pc[1:0]!=0), registered; otherwise 0.
- Redirect latency: target instruction appears on if_* two cycles after the redirect edge.
  - The redirect cycle shows if_valid=0, then IDLE shows if_valid=0.
- PC arithmetic wraps: 32'hFFFFFFFC + 4 = 0.
- Reset asserted mid-stall or mid-redirect: all state discarded immediately; fetch resumes from RESET_PC via IDLE.

Test Plan:
1. Preload mem[0..3]=11111111,22222222,33333333,44444444; release reset, stall=0 -> first cycle if_valid=0; then one per cycle: (if_pc 0, 11111111), (4, 22222222), (8, 33333333), (C, 44444444); if_pc_plus4 = if_pc+4.
2. Assert stall 3 cycles while if_pc=4 -> if_pc=4 and if_instr=22222222 stable, imem_read_en=0 during HOLD; after release the next accepted word is (8, 33333333), with no repeat of 4 and no gap.
3. redirect_valid with redirect_pc=0x40 while if_pc=8 (mem[16]=CAFEBABE) -> that cycle if_valid=0, next cycle if_valid=0, then (0x40, CAFEBABE).
4. In HOLD, assert stall=1 and redirect_valid=1 (redirect_pc=0x20) together -> redirect wins; if_valid=0 for 2 cycles, then if_pc=0x20 regardless of stall.
5. redirect_pc=0x42 -> fetch from 0x40, fetch_misaligned=1 for exactly one cycle after the redirect edge.
6. Assert reset asynchronously, between edges, during HOLD -> immediately if_valid=0, if_instr=00000013, imem_read_en=0; after release the first instruction is (RESET_PC, mem[0]).

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC generation and fetch stage ahead of a one-cycle-latency instruction memory
//
// Purpose:
//   Issues byte addresses to instruction memory, absorbs its one-cycle
//   registered read latency and presents an instruction/PC pair to decode.
//   A stall parks the live word in a skid register; a redirect flushes and
//   refetches from the (word-aligned) target.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   imem_addr/read_en   - request to instruction memory (addr is always pc)
//   imem_data_in        - word for the address issued in the previous cycle
//   stall               - decode is not accepting this cycle
//   redirect_valid/pc   - taken branch/jump and its target
//   if_valid/pc/pc_plus4/instr - instruction presented to decode
//   fetch_misaligned    - one-cycle pulse after a redirect to an unaligned target

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_read_en,
  input  logic [31:0] imem_data_in,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        misaligned_q, misaligned_d;

  logic        read_en_c;
  logic        valid_c;
  logic [31:0] instr_c;
  logic [31:0] pc_out_c;
  logic [31:0] redirect_target;

  // Targets are always fetched from the containing word.
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    read_en_c     = 1'b0;
    valid_c       = 1'b0;
    instr_c       = NOP_INSTR;
    pc_out_c      = inflight_pc_q;

    case (state_q)
      // No response pending: issue pc unconditionally, stall has no effect.
      S_IDLE: begin
        read_en_c     = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
        state_d       = S_RUN;
      end

      // imem_data_in is the word for inflight_pc_q.
      S_RUN: begin
        valid_c  = 1'b1;
        instr_c  = imem_data_in;
        pc_out_c = inflight_pc_q;
        if (redirect_valid) begin
          valid_c = 1'b0;
          pc_d    = redirect_target;
          state_d = S_IDLE;
        end else if (stall) begin
          // The memory output is only good for this cycle, so park it.
          hold_instr_d = imem_data_in;
          hold_pc_d    = inflight_pc_q;
          state_d      = S_HOLD;
        end else begin
          read_en_c     = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
        end
      end

      // pc_q already points past the held word, so releasing the stall
      // issues the successor immediately: no bubble and no refetch.
      S_HOLD: begin
        valid_c  = 1'b1;
        instr_c  = hold_instr_q;
        pc_out_c = hold_pc_q;
        if (redirect_valid) begin
          valid_c = 1'b0;
          pc_d    = redirect_target;
          state_d = S_IDLE;
        end else if (!stall) begin
          read_en_c     = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
          state_d       = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    misaligned_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= RESET_PC;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Reset gates the outputs directly so they are quiet for the whole time
  // reset is high, not just from the next edge.
  assign imem_addr        = pc_q;
  assign imem_read_en     = read_en_c & ~reset;
  assign if_valid         = valid_c & ~reset;
  assign if_instr         = if_valid ? instr_c : NOP_INSTR;
  assign if_pc            = reset ? RESET_PC : pc_out_c;
  assign if_pc_plus4      = if_pc + 32'd4;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
//
// Purpose:
//   Drives directed stall/redirect/reset sequences plus a short randomised
//   stall/redirect run against a bench-owned instruction memory, and checks
//   every cycle against an in-order fetch stream model.
//
// Ports: none (top-level bench).

module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_read_en;
  logic [31:0] imem_data_in;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_read_en    (imem_read_en),
    .imem_data_in    (imem_data_in),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered-read instruction memory.
  initial imem_data_in = 32'h0;
  always @(posedge clk) begin
    if (imem_read_en) imem_data_in <= mem[imem_addr[11:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: after reset or a redirect there is a fixed bubble, then
  // consecutive word addresses from the start point; each word stays on the
  // output until decode takes it.
  logic [31:0] exp_pc  = RESET_PC;
  int          bubbles = 1;
  logic        mis_exp = 1'b0;

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ren;
    if (reset) begin
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_instr", if_instr, NOP_INSTR);
      chk("rst_ren", {31'b0, imem_read_en}, 32'd0);
      chk("rst_pc", if_pc, RESET_PC);
      chk("rst_mis", {31'b0, fetch_misaligned}, 32'd0);
      exp_pc  = RESET_PC;
      bubbles = 1;
      mis_exp = 1'b0;
    end else begin
      exp_valid = (bubbles == 0) && !redirect_valid;
      exp_ren   = (bubbles > 0) ? 1'b1 : !(stall || redirect_valid);
      chk("valid", {31'b0, if_valid}, {31'b0, exp_valid});
      chk("read_en", {31'b0, imem_read_en}, {31'b0, exp_ren});
      chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, mis_exp});
      if (exp_ren) chk("imem_addr", imem_addr, (bubbles > 0) ? exp_pc : exp_pc + 32'd4);
      if (exp_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, mem[exp_pc[11:2]]);
        chk("if_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
      end else begin
        chk("nop_instr", if_instr, NOP_INSTR);
      end
      mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (bubbles > 0) begin
        bubbles--;
      end else if (redirect_valid) begin
        exp_pc  = redirect_pc & 32'hFFFF_FFFC;
        bubbles = 1;
      end else if (!stall) begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 + 32'(i);
    mem[0]  = 32'h1111_1111;
    mem[1]  = 32'h2222_2222;
    mem[2]  = 32'h3333_3333;
    mem[3]  = 32'h4444_4444;
    mem[16] = 32'hCAFE_BABE;

    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset release and straight-line fetch.
    @(negedge clk); chk("lit_first_bubble", {31'b0, if_valid}, 32'd0);
    tick(); @(negedge clk);
    chk("lit_pc0", if_pc, 32'h0); chk("lit_i0", if_instr, 32'h1111_1111); chk("lit_p4_0", if_pc_plus4, 32'h4);
    tick(); @(negedge clk); chk("lit_pc4", if_pc, 32'h4); chk("lit_i4", if_instr, 32'h2222_2222);
    tick(); @(negedge clk); chk("lit_pc8", if_pc, 32'h8); chk("lit_i8", if_instr, 32'h3333_3333);
    tick(); @(negedge clk); chk("lit_pcC", if_pc, 32'hC); chk("lit_iC", if_instr, 32'h4444_4444);

    // Return to 0x4, then stall there for three cycles.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick(); redirect_valid = 1'b0;
    tick(); stall = 1'b1;
    @(negedge clk); chk("lit_stall_pc", if_pc, 32'h4); chk("lit_stall_ren", {31'b0, imem_read_en}, 32'd0);
    tick(); @(negedge clk); chk("lit_hold_i", if_instr, 32'h2222_2222);
    tick(); @(negedge clk); chk("lit_hold_ren", {31'b0, imem_read_en}, 32'd0);
    tick(); stall = 1'b0;
    @(negedge clk); chk("lit_release_pc", if_pc, 32'h4);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk); chk("lit_after_hold_pc", if_pc, 32'h8); chk("lit_redir_valid", {31'b0, if_valid}, 32'd0);
    tick(); redirect_valid = 1'b0;
    @(negedge clk); chk("lit_redir_bubble", {31'b0, if_valid}, 32'd0);
    tick(); stall = 1'b1;
    @(negedge clk); chk("lit_pc40", if_pc, 32'h40); chk("lit_i40", if_instr, 32'hCAFE_BABE);

    // Redirect and stall together in HOLD: redirect wins.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick(); redirect_valid = 1'b0;
    tick(); @(negedge clk); chk("lit_pc20_stalled", if_pc, 32'h20); chk("lit_v20", {31'b0, if_valid}, 32'd1);

    // Misaligned redirect.
    tick(); stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk); chk("lit_mis_before", {31'b0, fetch_misaligned}, 32'd0);
    tick(); redirect_valid = 1'b0;
    @(negedge clk); chk("lit_mis_pulse", {31'b0, fetch_misaligned}, 32'd1);
    tick(); @(negedge clk); chk("lit_mis_after", {31'b0, fetch_misaligned}, 32'd0); chk("lit_pc40b", if_pc, 32'h40);

    // PC wrap at the top of the address space.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0;
    tick();
    tick(); @(negedge clk); chk("lit_pcFC", if_pc, 32'hFFFF_FFFC); chk("lit_wrap_p4", if_pc_plus4, 32'h0);
    tick(); @(negedge clk); chk("lit_wrap_pc0", if_pc, 32'h0); chk("lit_wrap_i0", if_instr, 32'h1111_1111);

    // Mixed stalls and redirects.
    for (int i = 0; i < 60; i++) begin
      tick();
      stall = ($urandom_range(0, 2) == 0);
      if (bubbles == 0 && $urandom_range(0, 7) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'($urandom_range(0, 4095));
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick(); stall = 1'b0; redirect_valid = 1'b0;
    tick();
    tick();
    tick();

    // Asynchronous reset in the middle of a HOLD cycle.
    tick(); stall = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("lit_arst_valid", {31'b0, if_valid}, 32'd0);
    chk("lit_arst_instr", if_instr, NOP_INSTR);
    chk("lit_arst_ren", {31'b0, imem_read_en}, 32'd0);
    tick();
    tick(); reset = 1'b0; stall = 1'b0;
    @(negedge clk); chk("lit_rerun_bubble", {31'b0, if_valid}, 32'd0);
    tick(); @(negedge clk); chk("lit_rerun_pc", if_pc, RESET_PC); chk("lit_rerun_i", if_instr, 32'h1111_1111);
    tick(); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
